axil_reg_bank: RTL
==================

AXIL_REG_BANK -- requirements
Module: axil_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6: AXI-Lite byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, 32 or 64 only.
REQ-003 SHALL have parameter NUM_REGS, default 12: implemented registers, 1..2**(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 SHALL have port s, axi_lite_interface.slave, carrying ACLK, ARSTN and all AXI-Lite channels.
REQ-005 s.ACLK  input  1  sole clock; all logic on its rising edge.
REQ-006 s.ARSTN  input  1  reset, asynchronous assert, active-low.
REQ-007 reg_q  output  NUM_REGS*DATA_WIDTH  flattened register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 reg_wr  output  NUM_REGS  one-cycle pulse per register on each committed in-range write.

Function
REQ-009 Word index SHALL be ADDR >> log2(DATA_WIDTH/8); low address bits ignored; index >= NUM_REGS is out-of-range.
REQ-010 AWREADY SHALL be 1 while no address is latched and BVALID=0; AW handshake latches AWADDR.
REQ-011 WREADY SHALL be 1 while no data is latched and BVALID=0; W handshake latches WDATA, WSTRB.
REQ-012 AW and W SHALL be accepted in either order or the same cycle; commit occurs the first cycle both are latched, combinationally or registered.
REQ-013 Commit SHALL update only bytes whose WSTRB bit is 1; WSTRB=0 commits nothing but still responds.
REQ-014 Commit SHALL assert BVALID next cycle and pulse reg_wr[index] on the commit cycle's following edge, coincident with reg_q changing.
REQ-015 Write FSM states W_IDLE (collecting AW/W), W_RESP (BVALID=1); W_RESP -> W_IDLE on BVALID&&BREADY, clearing both latches.
REQ-016 BVALID and BRESP SHALL hold stable until BREADY; no new AW/W accepted in W_RESP.
REQ-017 Read FSM states R_IDLE (ARREADY=1), R_DATA (RVALID=1, ARREADY=0); AR handshake -> R_DATA with RDATA registered from current reg_q.
REQ-018 R_DATA -> R_IDLE on RVALID&&RREADY; RDATA and RRESP stable until then; read latency exactly 1 cycle after AR handshake.
REQ-019 Read and write channels SHALL operate concurrently; a read of the register committed in the same cycle returns the pre-write value.
REQ-020 Minimum throughput: one write per 2 cycles, one read per 2 cycles.

Reset
REQ-021 ARSTN=0 SHALL asynchronously clear all registers to 0, both FSMs to idle, both latches empty.
REQ-022 During reset AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, reg_wr=0.
REQ-023 READY outputs SHALL rise no earlier than the first rising edge after ARSTN deasserts; in-flight transactions are discarded.

Configuration
REQ-024 With AXIL_REG_BANK_SLVERR_EN defined, out-of-range writes SHALL be discarded with BRESP=2'b10 and out-of-range reads SHALL return RDATA=0, RRESP=2'b10.
REQ-025 Without AXIL_REG_BANK_SLVERR_EN, out-of-range accesses SHALL behave identically except BRESP=RRESP=2'b00.
REQ-026 In-range accesses SHALL always return 2'b00 in either build.

Structure
REQ-027 Package axil_reg_bank_pkg SHALL hold RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and the write and read FSM state enums.
REQ-028 The AW/W capture-and-join logic SHALL be one sub-module, axil_wr_join, emitting commit with address, data, strobe.

Verification
REQ-029 AW 0x04 and W 0xDEADBEEF/STRB 0xF same cycle, BREADY=1 -> BVALID 1 cycle after commit, BRESP=00, reg_q reg1=0xDEADBEEF, reg_wr[1] one pulse.
REQ-030 W 0x000000AA/STRB 0x1 three cycles before AW 0x08 -> reg2 byte0=0xAA, other bytes unchanged, single commit.
REQ-031 Read 0x04 with RREADY low 5 cycles -> RVALID held, RDATA=0xDEADBEEF stable, ARREADY=0 throughout.
REQ-032 Write 0x3C (index 15, NUM_REGS=12), then read 0x3C -> no register change, RDATA=0, BRESP=RRESP=10 with macro, 00 without.
REQ-033 Same-cycle commit to reg3 (0x11111111 over 0) and AR 0x0C -> RDATA=0, subsequent read returns 0x11111111.
REQ-034 ARSTN low while BVALID=1 and RVALID=1 -> both drop immediately, all reg_q=0, ARREADY/AWREADY/WREADY high first edge after release.

Source files
------------

// File: rtl/axil_reg_bank_pkg.sv
// Shared definitions for the AXI-Lite register bank: response codes,
// write/read FSM state encodings and the response-selection helper.
package axil_reg_bank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,  // collecting AW and W
    W_RESP = 1'b1   // BVALID asserted, waiting for BREADY
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,  // ARREADY asserted
    R_DATA = 1'b1   // RVALID asserted, waiting for RREADY
  } rd_state_e;

  // Response code for an access: out-of-range only errors when enabled.
  function automatic logic [1:0] access_resp(input logic in_range, input logic slverr_en);
    if (in_range) begin
      return RESP_OKAY;
    end else if (slverr_en) begin
      return RESP_SLVERR;
    end else begin
      return RESP_OKAY;
    end
  endfunction

endpackage

// File: rtl/axil_reg_bank_if.sv
// AXI-Lite bus interface (clock, reset and all five channels) with
// master and slave modports.
interface axi_lite_interface #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                    ACLK;
  logic                    ARSTN;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  ACLK, ARSTN,
    input  AWADDR, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

  modport master (
    input  ACLK, ARSTN,
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );
endinterface

// File: rtl/axil_wr_join.sv
// AW/W capture-and-join: accepts address and data in either order (or
// together), holds them until the response completes, and raises commit
// in the first cycle both are available (live handshake or latched).
module axil_wr_join
  import axil_reg_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    accept_en,
  input  logic                    clear,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_valid,
  output logic                    w_ready,
  output logic                    commit,
  output logic [ADDR_WIDTH-1:0]   commit_addr,
  output logic [DATA_WIDTH-1:0]   commit_data,
  output logic [DATA_WIDTH/8-1:0] commit_strb
);

  logic                    aw_full_q, aw_full_d;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
  logic                    w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
  logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
  logic                    aw_hs_s, w_hs_s;

  assign aw_ready    = accept_en && !aw_full_q;
  assign w_ready     = accept_en && !w_full_q;
  assign aw_hs_s     = aw_valid && aw_ready;
  assign w_hs_s      = w_valid && w_ready;
  // Both halves present this cycle, whether just handshaken or latched earlier.
  assign commit      = accept_en && (aw_full_q || aw_hs_s) && (w_full_q || w_hs_s);
  assign commit_addr = aw_full_q ? aw_addr_q : aw_addr;
  assign commit_data = w_full_q ? w_data_q : w_data;
  assign commit_strb = w_full_q ? w_strb_q : w_strb;

  // Next-state of the address/data holding latches.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    if (clear) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_hs_s) begin
        aw_full_d = 1'b1;
        aw_addr_d = aw_addr;
      end else begin
        aw_full_d = aw_full_q;
      end
      if (w_hs_s) begin
        w_full_d = 1'b1;
        w_data_d = w_data;
        w_strb_d = w_strb;
      end else begin
        w_full_d = w_full_q;
      end
    end
  end

  // Latch registers, emptied asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
    end
  end

endmodule

// File: rtl/axil_reg_bank.sv
// AXI-Lite slave register bank with byte-strobed writes, independent
// read and write FSMs and flattened register outputs.
// Optional feature macro: AXIL_REG_BANK_SLVERR_EN -- when defined,
// out-of-range accesses answer SLVERR instead of OKAY.
module axil_reg_bank
  import axil_reg_bank_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 12
) (
  axi_lite_interface.slave               s,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
`ifdef AXIL_REG_BANK_SLVERR_EN
  localparam logic SLVERR_EN = 1'b1;
`else
  localparam logic SLVERR_EN = 1'b0;
`endif

  logic clk, rst_n;
  assign clk   = s.ACLK;
  assign rst_n = s.ARSTN;

  // Ready gating flop: keeps every READY low until the first edge after reset release.
  logic ready_en_q, ready_en_d;
  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word_s;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0] reg_wr_q, reg_wr_d;

  logic accept_en_s, b_hs_s, r_hs_s, ar_hs_s, commit_s;
  logic aw_ready_s, w_ready_s;
  logic [ADDR_WIDTH-1:0] commit_addr_s;
  logic [DATA_WIDTH-1:0] commit_data_s;
  logic [STRB_W-1:0]     commit_strb_s;
  logic [IDX_W-1:0]      wr_idx_s, rd_idx_s;
  logic                  wr_in_range_s, rd_in_range_s;
  logic                  addr_lsb_unused_s;

  assign accept_en_s = ready_en_q && (wr_state_q == W_IDLE);
  assign b_hs_s      = (wr_state_q == W_RESP) && s.BREADY;
  assign ar_hs_s     = s.ARVALID && s.ARREADY;
  assign r_hs_s      = (rd_state_q == R_DATA) && s.RREADY;

  axil_wr_join #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_join (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_en   (accept_en_s),
    .clear       (b_hs_s),
    .aw_addr     (s.AWADDR),
    .aw_valid    (s.AWVALID),
    .aw_ready    (aw_ready_s),
    .w_data      (s.WDATA),
    .w_strb      (s.WSTRB),
    .w_valid     (s.WVALID),
    .w_ready     (w_ready_s),
    .commit      (commit_s),
    .commit_addr (commit_addr_s),
    .commit_data (commit_data_s),
    .commit_strb (commit_strb_s)
  );

  // Word index drops the byte-offset bits; those bits are deliberately ignored.
  assign wr_idx_s          = commit_addr_s[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx_s          = s.ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_in_range_s     = (32'(wr_idx_s) < 32'(NUM_REGS));
  assign rd_in_range_s     = (32'(rd_idx_s) < 32'(NUM_REGS));
  assign addr_lsb_unused_s = ^{commit_addr_s[ADDR_LSB-1:0], s.ARADDR[ADDR_LSB-1:0]};

  assign s.AWREADY = aw_ready_s;
  assign s.WREADY  = w_ready_s;
  assign s.BVALID  = (wr_state_q == W_RESP);
  assign s.BRESP   = bresp_q;
  assign s.ARREADY = ready_en_q && (rd_state_q == R_IDLE);
  assign s.RVALID  = (rd_state_q == R_DATA);
  assign s.RDATA   = rdata_q;
  assign s.RRESP   = rresp_q;
  assign reg_q     = regs_q;
  assign reg_wr    = reg_wr_q;

  // Write FSM: commit moves to the response phase, B handshake returns to idle.
  always_comb begin
    ready_en_d = 1'b1;
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      W_IDLE: begin
        if (commit_s) begin
          wr_state_d = W_RESP;
          bresp_d    = access_resp(wr_in_range_s, SLVERR_EN);
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (b_hs_s) begin
          wr_state_d = W_IDLE;
        end else begin
          wr_state_d = W_RESP;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Register file update: strobed byte merge plus one write pulse per committed register.
  always_comb begin
    regs_d   = regs_q;
    reg_wr_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_s && (32'(wr_idx_s) == 32'(i))) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (commit_strb_s[b]) begin
            regs_d[i*DATA_WIDTH + b*8 +: 8] = commit_data_s[b*8 +: 8];
          end else begin
            regs_d[i*DATA_WIDTH + b*8 +: 8] = regs_q[i*DATA_WIDTH + b*8 +: 8];
          end
        end
        reg_wr_d[i] = |commit_strb_s;
      end else begin
        reg_wr_d[i] = 1'b0;
      end
    end
  end

  // Read FSM: capture the addressed word (pre-write value) on the AR handshake.
  always_comb begin
    rd_word_s  = '0;
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx_s) == 32'(i)) begin
        rd_word_s = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
    case (rd_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          rd_state_d = R_DATA;
          rdata_d    = rd_in_range_s ? rd_word_s : '0;
          rresp_d    = access_resp(rd_in_range_s, SLVERR_EN);
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_hs_s) begin
          rd_state_d = R_IDLE;
        end else begin
          rd_state_d = R_DATA;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State, response and register flops, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      regs_q     <= '0;
      reg_wr_q   <= '0;
    end else begin
      ready_en_q <= ready_en_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      regs_q     <= regs_d;
      reg_wr_q   <= reg_wr_d;
    end
  end

endmodule
